// File: rtl/univ_shift_reg_burst.sv
// rtl/univ_shift_reg_burst.sv - parametrised universal shift register with burst engine
//
// Purpose: WIDTH-bit universal shift register with eight modes (hold, shift
// right/left, load, rotate right/left, arithmetic shift right, clear). In IDLE
// a single op is applied when en=1; a start request latches mode and count and
// applies that mode for count consecutive cycles, then pulses done.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous reset, active-high
//   en           single-step enable (IDLE only)
//   mode         operation select
//   start        burst request (IDLE only, priority over en)
//   count        burst step count, sampled with start
//   parallel_in  parallel load data
//   right_in     serial input entering the MSB on shift right
//   left_in      serial input entering the LSB on shift left
//   q            register contents
//   serial_out_r q[0]
//   serial_out_l q[WIDTH-1]
//   busy         burst in progress (RUN state)
//   done         one-cycle burst completion pulse
module univ_shift_reg_burst #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    input  logic [WIDTH-1:0] parallel_in,
    input  logic             right_in,
    input  logic             left_in,
    output logic [WIDTH-1:0] q,
    output logic             serial_out_r,
    output logic             serial_out_l,
    output logic             busy,
    output logic             done
);

    localparam logic [2:0] M_HOLD  = 3'b000;
    localparam logic [2:0] M_SHR   = 3'b001;
    localparam logic [2:0] M_SHL   = 3'b010;
    localparam logic [2:0] M_LOAD  = 3'b011;
    localparam logic [2:0] M_ROR   = 3'b100;
    localparam logic [2:0] M_ROL   = 3'b101;
    localparam logic [2:0] M_ASR   = 3'b110;
    localparam logic [2:0] M_CLR   = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [2:0]       lat_mode;
    logic [CNT_W-1:0] remaining;
    logic [2:0]       op_mode;
    logic [WIDTH-1:0] op_q;
    logic             do_op;
    logic             load_burst;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    next_state = (count == '0) ? S_DONE : S_RUN;
                end
            end
            // remaining holds the steps still to do including this cycle's op
            S_RUN: begin
                if (remaining == CNT_W'(1)) begin
                    next_state = S_DONE;
                end
            end
            S_DONE:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Output / control decode
    always_comb begin
        busy       = 1'b0;
        done       = 1'b0;
        do_op      = 1'b0;
        load_burst = 1'b0;
        case (state)
            S_IDLE: begin
                load_burst = start;
                do_op      = en & ~start;
            end
            S_RUN: begin
                busy  = 1'b1;
                do_op = 1'b1;
            end
            S_DONE: done = 1'b1;
            default: ;
        endcase
    end

    // During a burst the latched mode is used; serial/parallel data stay live
    assign op_mode = (state == S_RUN) ? lat_mode : mode;

    always_comb begin
        op_q = q;
        case (op_mode)
            M_HOLD: op_q = q;
            M_SHR:  op_q = {right_in, q[WIDTH-1:1]};
            M_SHL:  op_q = {q[WIDTH-2:0], left_in};
            M_LOAD: op_q = parallel_in;
            M_ROR:  op_q = {q[0], q[WIDTH-1:1]};
            M_ROL:  op_q = {q[WIDTH-2:0], q[WIDTH-1]};
            M_ASR:  op_q = {q[WIDTH-1], q[WIDTH-1:1]};
            M_CLR:  op_q = '0;
            default: op_q = q;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            q         <= '0;
            remaining <= '0;
            lat_mode  <= M_HOLD;
        end else begin
            if (do_op) begin
                q <= op_q;
            end
            if (load_burst) begin
                lat_mode  <= mode;
                remaining <= count;
            end else if (state == S_RUN) begin
                remaining <= remaining - CNT_W'(1);
            end
        end
    end

    assign serial_out_r = q[0];
    assign serial_out_l = q[WIDTH-1];

endmodule

// File: tb/tb_univ_shift_reg_burst.sv
// tb/tb_univ_shift_reg_burst.sv - scoreboard bench for univ_shift_reg_burst
module tb_univ_shift_reg_burst;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic [2:0]       mode;
    logic             start;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] parallel_in;
    logic             right_in;
    logic             left_in;
    logic [WIDTH-1:0] q;
    logic             serial_out_r;
    logic             serial_out_l;
    logic             busy;
    logic             done;

    typedef struct {
        logic [WIDTH-1:0] q;
        logic             busy;
        logic             done;
        string            name;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    univ_shift_reg_burst #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .mode         (mode),
        .start        (start),
        .count        (count),
        .parallel_in  (parallel_in),
        .right_in     (right_in),
        .left_in      (left_in),
        .q            (q),
        .serial_out_r (serial_out_r),
        .serial_out_l (serial_out_l),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    // Let one active edge pass with the current inputs, then queue what the
    // DUT must show for the following cycle.
    task automatic tick(input logic [WIDTH-1:0] eq, input logic eb,
                        input logic ed, input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        e.q = eq; e.busy = eb; e.done = ed; e.name = nm;
        sb.push_back(e);
    endtask

    // Monitor: compares DUT outputs at mid-cycle against the scoreboard head
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            if (q !== e.q || busy !== e.busy || done !== e.done ||
                serial_out_r !== e.q[0] || serial_out_l !== e.q[WIDTH-1]) begin
                failures++;
                $display("FAIL %s: got q=%02h busy=%b done=%b sr=%b sl=%b, want q=%02h busy=%b done=%b sr=%b sl=%b",
                         e.name, q, busy, done, serial_out_r, serial_out_l,
                         e.q, e.busy, e.done, e.q[0], e.q[WIDTH-1]);
            end
        end
    end

    logic [7:0] ser_bits [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [7:0] ser_exp  [8] = '{8'h80, 8'h40, 8'hA0, 8'hD0, 8'h68, 8'h34, 8'h9A, 8'h4D};
    logic [7:0] ror_exp  [4] = '{8'h80, 8'h40, 8'h20, 8'h10};

    initial begin
        rst = 1'b1; en = 1'b0; mode = 3'b000; start = 1'b0; count = '0;
        parallel_in = '0; right_in = 1'b0; left_in = 1'b0;
        tick(8'h00, 1'b0, 1'b0, "reset_state");
        rst = 1'b0;

        // Single steps
        en = 1'b1; mode = 3'b011; parallel_in = 8'hA5;
        tick(8'hA5, 1'b0, 1'b0, "load_a5");
        mode = 3'b100; tick(8'hD2, 1'b0, 1'b0, "ror");
        mode = 3'b101; tick(8'hA5, 1'b0, 1'b0, "rol");
        mode = 3'b011; parallel_in = 8'h85; tick(8'h85, 1'b0, 1'b0, "load_85");
        mode = 3'b110; tick(8'hC2, 1'b0, 1'b0, "asr");
        mode = 3'b111; tick(8'h00, 1'b0, 1'b0, "clear");
        en = 1'b0; mode = 3'b011; parallel_in = 8'hFF;
        for (int i = 0; i < 3; i++) tick(8'h00, 1'b0, 1'b0, "hold_en0");
        en = 1'b1; parallel_in = 8'h3C; tick(8'h3C, 1'b0, 1'b0, "load_3c");
        mode = 3'b001; right_in = 1'b1; tick(8'h9E, 1'b0, 1'b0, "shr");
        mode = 3'b010; left_in = 1'b0; tick(8'h3C, 1'b0, 1'b0, "shl");

        // Burst shift left
        mode = 3'b011; parallel_in = 8'h81; tick(8'h81, 1'b0, 1'b0, "load_81");
        en = 1'b0; start = 1'b1; mode = 3'b010; count = 4'd3; left_in = 1'b1;
        tick(8'h81, 1'b1, 1'b0, "shl_burst_e0");
        start = 1'b0; mode = 3'b000;
        tick(8'h03, 1'b1, 1'b0, "shl_burst_1");
        tick(8'h07, 1'b1, 1'b0, "shl_burst_2");
        tick(8'h0F, 1'b0, 1'b1, "shl_burst_3");
        tick(8'h0F, 1'b0, 1'b0, "shl_burst_after");

        // Burst serial stream
        en = 1'b1; mode = 3'b011; parallel_in = 8'h00; tick(8'h00, 1'b0, 1'b0, "load_00");
        en = 1'b0; start = 1'b1; mode = 3'b001; count = 4'd8;
        tick(8'h00, 1'b1, 1'b0, "ser_e0");
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            right_in = ser_bits[i][0];
            tick(ser_exp[i], (i < 7), (i == 7), "ser_step");
        end
        tick(8'h4D, 1'b0, 1'b0, "ser_after");

        // Zero count: clear mode must not act
        start = 1'b1; mode = 3'b111; count = 4'd0;
        tick(8'h4D, 1'b0, 1'b1, "zero_done");
        start = 1'b0;
        tick(8'h4D, 1'b0, 1'b0, "zero_after");

        // Ignored inputs during rotate-right burst
        en = 1'b1; mode = 3'b011; parallel_in = 8'h01; tick(8'h01, 1'b0, 1'b0, "load_01");
        en = 1'b0; start = 1'b1; mode = 3'b100; count = 4'd4;
        tick(8'h01, 1'b1, 1'b0, "ign_e0");
        parallel_in = 8'hFF;
        for (int i = 0; i < 4; i++) begin
            en = i[0]; start = ~i[0]; mode = i[0] ? 3'b011 : 3'b111; count = 4'd9;
            tick(ror_exp[i], (i < 3), (i == 3), "ign_step");
        end
        en = 1'b1; start = 1'b1; mode = 3'b010; count = 4'd1; left_in = 1'b0;
        tick(8'h10, 1'b0, 1'b0, "start_in_done_ignored");
        en = 1'b0;
        tick(8'h10, 1'b1, 1'b0, "start_next_idle");
        start = 1'b0;
        tick(8'h20, 1'b0, 1'b1, "restart_done");
        tick(8'h20, 1'b0, 1'b0, "restart_after");

        // Reset mid-burst
        start = 1'b1; mode = 3'b100; count = 4'd15;
        tick(8'h20, 1'b1, 1'b0, "abort_e0");
        start = 1'b0;
        tick(8'h10, 1'b1, 1'b0, "abort_step");
        rst = 1'b1;
        tick(8'h00, 1'b0, 1'b0, "abort_reset");
        rst = 1'b0;
        for (int i = 0; i < 3; i++) tick(8'h00, 1'b0, 1'b0, "abort_no_done");

        @(negedge clk);
        @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
